run_sample_scheduler: RTL and testbench

// - Sequences a single shared step-calculator datapath between two runners.
// - Each runner delivers HR and steps-per-second samples over a req/ack channel.
// - A one-second tick is derived from clk. On each tick the block dispatches each runner's held sample, round-robin, as one valid pulse.
// - A session FSM bounds the run and supports pause, stop and done.

---
 rtl/run_sched_pkg.sv | 32 +++
 rtl/sample_slot.sv | 73 +++++++
 rtl/run_sample_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_run_sample_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/run_sched_pkg.sv
// run_sched_pkg: shared types and helpers for the two-runner sample scheduler.
//   sched_state_t  session FSM states
//   win_phase_t    dispatch window phase after each one-second tick
//   RUNNER_1/2     out_sel encodings
//   hr_t/steps_t   sample field types
//   sat_inc8       saturating 8-bit increment used by all event counters
package run_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } sched_state_t;

  typedef enum logic [1:0] {
    WIN_IDLE,
    WIN_FIRST,
    WIN_SECOND
  } win_phase_t;

  localparam logic RUNNER_1 = 1'b0;
  localparam logic RUNNER_2 = 1'b1;

  typedef logic [7:0] hr_t;
  typedef logic [2:0] steps_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/sample_slot.sv
// sample_slot: one runner's single-entry sample buffer.
//   clk, rst          clock, asynchronous active-low reset
//   cap_en            captures allowed (session running or paused)
//   req, hr, steps    runner offers a sample
//   ack               same-cycle acknowledge of a capture (valid or not)
//   tick              one-second tick; an empty slot counts a miss
//   disp              slot is being dispatched this cycle; empties it
//   clr_slot          drop any held sample
//   clr_cnt           zero the miss/err counters
//   full, held_*      buffer state and held sample
//   miss_cnt, err_cnt saturating event counters
module sample_slot
  import run_sched_pkg::*;
#(
  parameter int HR_MAX = 220
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cap_en,
  input  logic       req,
  input  logic [7:0] hr,
  input  logic [2:0] steps,
  input  logic       tick,
  input  logic       disp,
  input  logic       clr_slot,
  input  logic       clr_cnt,
  output logic       ack,
  output logic       full,
  output logic [7:0] held_hr,
  output logic [2:0] held_steps,
  output logic [7:0] miss_cnt,
  output logic [7:0] err_cnt
);

  logic hr_ok;

  assign hr_ok = (hr != 8'd0) && (hr <= hr_t'(HR_MAX));

  // An invalid sample is still acknowledged so the runner does not stall on it.
  assign ack = cap_en && req && !full;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full       <= 1'b0;
      held_hr    <= '0;
      held_steps <= '0;
    end else if (clr_slot) begin
      full <= 1'b0;
    end else if (ack && hr_ok) begin
      full       <= 1'b1;
      held_hr    <= hr_t'(hr);
      held_steps <= steps_t'(steps);
    end else if (disp) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_cnt <= '0;
      err_cnt  <= '0;
    end else if (clr_cnt) begin
      miss_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (ack && !hr_ok) err_cnt <= sat_inc8(err_cnt);
      if (tick && !full) miss_cnt <= sat_inc8(miss_cnt);
    end
  end

endmodule

// File: rtl/run_sample_scheduler.sv
// run_sample_scheduler: shares one step-calculator datapath between two
// runners. Samples are buffered per runner, and on every one-second tick the
// held samples are dispatched round-robin as one out_valid pulse each.
//   clk, rst                    clock, asynchronous active-low reset
//   start / pause / stop        session control (pulse / level / pulse)
//   req_n, hr_n, steps_n        runner sample offer; ack_n acknowledges
//   out_valid/sel/hr/steps      dispatch strobe and sample to the datapath
//   busy, session_done          RUN-or-PAUSE, DONE
//   elapsed_secs                ticks counted this session
//   miss_cnt_n, err_cnt_n       per-runner saturating miss/invalid counters
module run_sample_scheduler
  import run_sched_pkg::*;
#(
  parameter int CLK_PER_SEC  = 10,
  parameter int SESSION_SECS = 20,
  parameter int HR_MAX       = 220
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic       req_1,
  input  logic       req_2,
  input  logic [7:0] hr_1,
  input  logic [7:0] hr_2,
  input  logic [2:0] steps_1,
  input  logic [2:0] steps_2,
  output logic       ack_1,
  output logic       ack_2,
  output logic       out_valid,
  output logic       out_sel,
  output logic [7:0] out_hr,
  output logic [2:0] out_steps,
  output logic       busy,
  output logic       session_done,
  output logic [7:0] elapsed_secs,
  output logic [7:0] miss_cnt_1,
  output logic [7:0] miss_cnt_2,
  output logic [7:0] err_cnt_1,
  output logic [7:0] err_cnt_2
);

  localparam int                DIV_W     = $clog2(CLK_PER_SEC);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_PER_SEC - 1);
  localparam logic [7:0]        SESS_LAST = 8'(SESSION_SECS);

  sched_state_t     state_q, state_d;
  win_phase_t       phase_q;
  logic [1:0]       pend_q;      // {runner2, runner1} still owed a dispatch
  logic             rr_q;        // runner dispatched first when both pending
  logic [DIV_W-1:0] div_q;
  logic [7:0]       elapsed_q;

  logic in_run, is_busy, win_idle, tick, session_end, restart, to_done;
  logic full_1, full_2, disp_1, disp_2, cap_en;
  logic [7:0] held_hr_1, held_hr_2;
  logic [2:0] held_steps_1, held_steps_2;

  assign in_run   = (state_q == RUN);
  assign is_busy  = (state_q == RUN) || (state_q == PAUSE);
  assign win_idle = (phase_q == WIN_IDLE);

  // stop beats a coincident tick so a stopped session never counts one more second.
  assign tick = in_run && (div_q == DIV_LAST) && (elapsed_q < SESS_LAST) && !stop;

  // The session ends only once the final tick's dispatch window has drained.
  assign session_end = in_run && (elapsed_q == SESS_LAST) && win_idle;

  assign restart = start && ((state_q == IDLE) || (state_q == DONE));
  assign to_done = is_busy && (state_d == DONE);
  assign cap_en  = is_busy && !to_done;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // Pause is held off while a dispatch window is open so the window completes.
  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no
    // latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN: begin
        if (stop || session_end)               state_d = DONE;
        else if (pause && win_idle && !tick)   state_d = PAUSE;
      end
      PAUSE: begin
        if (stop)        state_d = DONE;
        else if (!pause) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs and dispatch mux ----------------
  always_comb begin
    out_valid    = 1'b0;
    out_sel      = RUNNER_1;
    out_hr       = '0;
    out_steps    = '0;
    case (phase_q)
      WIN_FIRST: begin
        out_valid = |pend_q;
        out_sel   = (&pend_q) ? rr_q : pend_q[1];
      end
      WIN_SECOND: begin
        out_valid = |pend_q;
        out_sel   = pend_q[1];
      end
      default: ;
    endcase
    if (out_valid) begin
      out_hr    = (out_sel == RUNNER_2) ? held_hr_2    : held_hr_1;
      out_steps = (out_sel == RUNNER_2) ? held_steps_2 : held_steps_1;
    end
    busy         = is_busy;
    session_done = (state_q == DONE);
  end

  assign disp_1 = out_valid && (out_sel == RUNNER_1);
  assign disp_2 = out_valid && (out_sel == RUNNER_2);

  // ---------------- tick divider and elapsed seconds ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q     <= '0;
      elapsed_q <= '0;
    end else if (restart) begin
      div_q     <= '0;
      elapsed_q <= '0;
    end else if (in_run) begin
      div_q <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      if (tick) elapsed_q <= elapsed_q + 8'd1;
    end
  end

  assign elapsed_secs = elapsed_q;

  // ---------------- dispatch window and round-robin ----------------
  // Slot occupancy is snapshotted at the tick, so samples captured while the
  // window is open wait for the next tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= WIN_IDLE;
      pend_q  <= '0;
      rr_q    <= 1'b0;
    end else if (restart || to_done) begin
      phase_q <= WIN_IDLE;
      pend_q  <= '0;
      if (restart) rr_q <= 1'b0;
    end else if (tick) begin
      phase_q <= WIN_FIRST;
      pend_q  <= {full_2, full_1};
    end else begin
      case (phase_q)
        WIN_FIRST: begin
          if (&pend_q) begin
            phase_q <= WIN_SECOND;
            pend_q  <= rr_q ? 2'b01 : 2'b10;
          end else begin
            phase_q <= WIN_IDLE;
            pend_q  <= '0;
          end
        end
        WIN_SECOND: begin
          phase_q <= WIN_IDLE;
          pend_q  <= '0;
          rr_q    <= ~rr_q;
        end
        default: ;
      endcase
    end
  end

  // ---------------- per-runner slots ----------------
  sample_slot #(.HR_MAX(HR_MAX)) u_slot_1 (
    .clk        (clk),
    .rst        (rst),
    .cap_en     (cap_en),
    .req        (req_1),
    .hr         (hr_1),
    .steps      (steps_1),
    .tick       (tick),
    .disp       (disp_1),
    .clr_slot   (to_done || restart),
    .clr_cnt    (restart),
    .ack        (ack_1),
    .full       (full_1),
    .held_hr    (held_hr_1),
    .held_steps (held_steps_1),
    .miss_cnt   (miss_cnt_1),
    .err_cnt    (err_cnt_1)
  );

  sample_slot #(.HR_MAX(HR_MAX)) u_slot_2 (
    .clk        (clk),
    .rst        (rst),
    .cap_en     (cap_en),
    .req        (req_2),
    .hr         (hr_2),
    .steps      (steps_2),
    .tick       (tick),
    .disp       (disp_2),
    .clr_slot   (to_done || restart),
    .clr_cnt    (restart),
    .ack        (ack_2),
    .full       (full_2),
    .held_hr    (held_hr_2),
    .held_steps (held_steps_2),
    .miss_cnt   (miss_cnt_2),
    .err_cnt    (err_cnt_2)
  );

endmodule

// File: tb/tb_run_sample_scheduler.sv
// Directed bench for run_sample_scheduler (CLK_PER_SEC=10, SESSION_SECS=20).
// Inputs change 2 ns after a rising edge; outputs are checked 1 ns later and
// the dispatch monitor samples on the falling edge.
module tb_run_sample_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic       req_1 = 1'b0, req_2 = 1'b0;
  logic [7:0] hr_1 = '0, hr_2 = '0;
  logic [2:0] steps_1 = '0, steps_2 = '0;
  logic       ack_1, ack_2, out_valid, out_sel, busy, session_done;
  logic [7:0] out_hr, elapsed_secs, miss_cnt_1, miss_cnt_2, err_cnt_1, err_cnt_2;
  logic [2:0] out_steps;

  run_sample_scheduler #(
    .CLK_PER_SEC(10), .SESSION_SECS(20), .HR_MAX(220)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
    .req_1(req_1), .req_2(req_2), .hr_1(hr_1), .hr_2(hr_2),
    .steps_1(steps_1), .steps_2(steps_2), .ack_1(ack_1), .ack_2(ack_2),
    .out_valid(out_valid), .out_sel(out_sel), .out_hr(out_hr),
    .out_steps(out_steps), .busy(busy), .session_done(session_done),
    .elapsed_secs(elapsed_secs), .miss_cnt_1(miss_cnt_1),
    .miss_cnt_2(miss_cnt_2), .err_cnt_1(err_cnt_1), .err_cnt_2(err_cnt_2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic       sel;
    logic [7:0] hr;
    logic [2:0] st;
  } disp_t;

  disp_t dq[$];
  int    ack1_cnt = 0;

  always @(negedge clk) begin
    if (out_valid) dq.push_back('{c: cyc, sel: out_sel, hr: out_hr, st: out_steps});
    if (ack_1) ack1_cnt <= ack1_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  // Expected dispatch order over three double-sample ticks: (1,2),(2,1),(1,2).
  int exp_sel[6] = '{0, 1, 1, 0, 0, 1};
  int exp_off[6] = '{21, 22, 31, 32, 41, 42};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) clk1();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, e, d, base, n;
    disp_t en;

    // ---------------- reset state ----------------
    clk1(); clk1();
    rst = 1'b1;
    clk1(); #1;
    check("rst_busy", busy, 0);
    check("rst_done", session_done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_elapsed", elapsed_secs, 0);
    check("rst_miss1", miss_cnt_1, 0);
    check("rst_err2", err_cnt_2, 0);

    // req in IDLE is never acknowledged
    req_1 = 1'b1; hr_1 = 8'd100; #1;
    check("idle_no_ack", ack_1, 0);

    // ---------------- first sample and first tick ----------------
    clk1();
    req_1 = 1'b0;
    s = cyc;
    start = 1'b1;
    clk1();                                   // S+1: RUN, divider 0
    start = 1'b0;
    req_1 = 1'b1; hr_1 = 8'd110; steps_1 = 3'd2; #1;
    check("first_ack1", ack_1, 1);
    check("run_busy", busy, 1);
    clk1(); #1;                               // S+2: slot full
    check("ack1_one_cycle", ack_1, 0);
    req_1 = 1'b0;
    wait_cyc(s + 11); #1;                     // tick at S+10, dispatch at S+11
    check("t1_valid", out_valid, 1);
    check("t1_sel", out_sel, 0);
    check("t1_hr", out_hr, 110);
    check("t1_steps", out_steps, 2);
    clk1(); #1;
    check("t1_no_second", out_valid, 0);
    check("t1_miss2", miss_cnt_2, 1);
    check("t1_miss1", miss_cnt_1, 0);
    check("t1_elapsed", elapsed_secs, 1);

    // ---------------- both runners, three ticks ----------------
    base = dq.size();
    for (int k = 0; k < 3; k++) begin
      wait_cyc(s + 13 + 10 * k);
      req_1 = 1'b1; hr_1 = 8'(120 + k); steps_1 = 3'd3;
      req_2 = 1'b1; hr_2 = 8'(130 + k); steps_2 = 3'd4;
      #1;
      check("both_ack1", ack_1, 1);
      check("both_ack2", ack_2, 1);
      clk1();
      req_1 = 1'b0; req_2 = 1'b0;
    end
    wait_cyc(s + 43);
    check("rr_count", dq.size() - base, 6);
    for (int i = 0; i < 6; i++) begin
      if (base + i < dq.size()) begin
        en = dq[base + i];
        check("rr_sel", en.sel, exp_sel[i]);
        check("rr_hr", en.hr, exp_sel[i] == 1 ? 130 + i / 2 : 120 + i / 2);
        check("rr_cycle", en.c, s + exp_off[i]);
      end
    end
    check("rr_miss2", miss_cnt_2, 1);
    check("rr_elapsed", elapsed_secs, 4);

    // ---------------- invalid hr on runner 2 ----------------
    req_2 = 1'b1; hr_2 = 8'd0; steps_2 = 3'd1; #1;   // S+43
    check("inv0_ack2", ack_2, 1);
    clk1();
    hr_2 = 8'd230; #1;                                // S+44
    check("inv230_ack2", ack_2, 1);
    clk1();
    req_2 = 1'b0; #1;                                 // S+45
    check("inv_err2", err_cnt_2, 2);
    base = dq.size();
    wait_cyc(s + 51); #1;                             // tick5 at S+50
    check("inv_miss2", miss_cnt_2, 2);
    check("inv_miss1", miss_cnt_1, 1);
    wait_cyc(s + 53);
    check("inv_no_disp", dq.size() - base, 0);

    // ---------------- pause held 25 cycles ----------------
    pause = 1'b1;                                     // S+53 .. S+77
    wait_cyc(s + 60); #1;
    check("pause_busy", busy, 1);
    check("pause_elapsed", elapsed_secs, 5);
    req_1 = 1'b1; hr_1 = 8'd150; steps_1 = 3'd6; #1;
    check("pause_ack1", ack_1, 1);
    clk1();
    req_1 = 1'b0;
    wait_cyc(s + 78);
    pause = 1'b0; #1;
    check("pause_frozen", elapsed_secs, 5);
    check("pause_no_disp", dq.size() - base, 0);
    wait_cyc(s + 86); #1;                             // divider resumes at 3: tick6 at S+85
    check("resume_valid", out_valid, 1);
    check("resume_hr", out_hr, 150);
    check("resume_elapsed", elapsed_secs, 6);
    check("resume_miss2", miss_cnt_2, 3);

    // ---------------- session end ----------------
    wait_cyc(s + 227); #1;                            // tick20 at S+225, window drains
    check("end_busy_before", busy, 1);
    clk1(); #1;
    check("end_done", session_done, 1);
    check("end_busy", busy, 0);
    check("end_elapsed", elapsed_secs, 20);
    wait_cyc(s + 240); #1;
    check("end_elapsed_hold", elapsed_secs, 20);

    // ---------------- restart from DONE, then reset mid-RUN ----------------
    d = cyc;
    start = 1'b1;
    clk1(); #1;
    start = 1'b0;
    check("restart_busy", busy, 1);
    check("restart_elapsed", elapsed_secs, 0);
    check("restart_miss2", miss_cnt_2, 0);
    check("restart_err2", err_cnt_2, 0);
    wait_cyc(d + 4);
    rst = 1'b0; #1;
    check("async_rst_busy", busy, 0);
    clk1();
    rst = 1'b1;
    n = ack1_cnt;
    req_1 = 1'b1; hr_1 = 8'd100; steps_1 = 3'd1; #1;
    check("post_rst_ack1", ack_1, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", out_valid, 0);
    check("post_rst_miss2", miss_cnt_2, 0);
    clk1(); clk1(); clk1(); #1;
    check("post_rst_no_ack", ack1_cnt, n);
    check("post_rst_done", session_done, 0);
    req_1 = 1'b0;

    // ---------------- stop at T+1 with both slots full ----------------
    clk1();
    e = cyc;
    start = 1'b1;
    clk1();
    start = 1'b0;
    clk1();                                           // E+2
    req_1 = 1'b1; hr_1 = 8'd90; steps_1 = 3'd1;
    req_2 = 1'b1; hr_2 = 8'd95; steps_2 = 3'd5; #1;
    check("stop_ack1", ack_1, 1);
    check("stop_ack2", ack_2, 1);
    clk1();
    req_1 = 1'b0; req_2 = 1'b0;
    base = dq.size();
    wait_cyc(e + 11);
    stop = 1'b1; #1;
    check("stop_t1_valid", out_valid, 1);
    check("stop_t1_sel", out_sel, 0);
    check("stop_t1_hr", out_hr, 90);
    clk1(); #1;
    stop = 1'b0;
    check("stop_t2_valid", out_valid, 0);
    check("stop_done", session_done, 1);
    check("stop_busy", busy, 0);
    wait_cyc(e + 20);
    check("stop_disp_count", dq.size() - base, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
